// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_stage
//  Purpose  : MIPS-subset decode/issue register between the decode stage and
//             the ALU. Decodes the offered instruction, selects operands
//             (with optional EX/MEM and MEM/WB forwarding), and holds the
//             result in a valid/ready output register.
//  Config   : ALU_ISSUE_FWD_EN - when defined, source operands are forwarded
//             from EX/MEM (highest priority) then MEM/WB; when undefined the
//             register-file reads are used directly.
//  Ports    : clk, rst_n (sync, active-low)
//             in_valid/in_ready, instr, rs_data, rt_data   - decode side
//             exmem_wr_en/rd/result, memwb_wr_en/rd/result - bypass sources
//             flush                                        - kill held/offered
//             ex_valid/ex_ready, alu_op1, alu_op2,
//             alu_control, ex_rd, ex_wr_en, ex_illegal     - execute side
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        exmem_wr_en,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_wr_en,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    input  logic        flush,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [2:0]  alu_control,
    output logic [4:0]  ex_rd,
    output logic        ex_wr_en,
    output logic        ex_illegal
);

    // ALU operation codes
    localparam logic [2:0] c_alu_add   = 3'b000;
    localparam logic [2:0] c_alu_sub   = 3'b001;
    localparam logic [2:0] c_alu_shift = 3'b010;
    localparam logic [2:0] c_alu_and   = 3'b011;
    localparam logic [2:0] c_alu_or    = 3'b100;
    localparam logic [2:0] c_alu_xor   = 3'b101;
    localparam logic [2:0] c_alu_nor   = 3'b110;
    localparam logic [2:0] c_alu_nop   = 3'b111;

    // Opcodes and R-type function codes
    localparam logic [5:0] c_op_rtype  = 6'b000000;
    localparam logic [5:0] c_op_j      = 6'b000010;
    localparam logic [5:0] c_op_addi   = 6'b001000;
    localparam logic [5:0] c_fn_sll    = 6'b000000;
    localparam logic [5:0] c_fn_add    = 6'b100000;
    localparam logic [5:0] c_fn_sub    = 6'b100010;
    localparam logic [5:0] c_fn_and    = 6'b100100;
    localparam logic [5:0] c_fn_or     = 6'b100101;
    localparam logic [5:0] c_fn_xor    = 6'b100110;
    localparam logic [5:0] c_fn_nor    = 6'b100111;

    // Instruction fields
    logic [5:0]  w_opcode;
    logic [4:0]  w_rs_idx;
    logic [4:0]  w_rt_idx;
    logic [4:0]  w_rd_idx;
    logic [4:0]  w_shamt;
    logic [5:0]  w_funct;
    logic [31:0] w_imm_sext;

    assign w_opcode   = instr[31:26];
    assign w_rs_idx   = instr[25:21];
    assign w_rt_idx   = instr[20:16];
    assign w_rd_idx   = instr[15:11];
    assign w_shamt    = instr[10:6];
    assign w_funct    = instr[5:0];
    assign w_imm_sext = {{16{instr[15]}}, instr[15:0]};

    // Output register
    logic        r_valid;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic [2:0]  r_ctl;
    logic [4:0]  r_rd;
    logic        r_wr_en;
    logic        r_illegal;

    // Handshake: flush blocks acceptance so a flushed offer is never taken
    logic w_accept;
    assign in_ready = (!r_valid || ex_ready) && !flush;
    assign w_accept = in_valid && in_ready;

    // Source operand selection. Register 0 always reads as zero, even if a
    // bypass source claims to write it.
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;

`ifdef ALU_ISSUE_FWD_EN
    always_comb begin
        w_rs_val = rs_data;
        if (exmem_wr_en && (exmem_rd == w_rs_idx)) begin
            w_rs_val = exmem_result;
        end else if (memwb_wr_en && (memwb_rd == w_rs_idx)) begin
            w_rs_val = memwb_result;
        end
        if (w_rs_idx == 5'd0) begin
            w_rs_val = 32'd0;
        end
    end

    always_comb begin
        w_rt_val = rt_data;
        if (exmem_wr_en && (exmem_rd == w_rt_idx)) begin
            w_rt_val = exmem_result;
        end else if (memwb_wr_en && (memwb_rd == w_rt_idx)) begin
            w_rt_val = memwb_result;
        end
        if (w_rt_idx == 5'd0) begin
            w_rt_val = 32'd0;
        end
    end
`else
    // Bypass inputs are intentionally ignored in this build
    logic w_unused_fwd;
    assign w_unused_fwd = ^{exmem_wr_en, exmem_rd, exmem_result,
                            memwb_wr_en, memwb_rd, memwb_result};

    assign w_rs_val = (w_rs_idx == 5'd0) ? 32'd0 : rs_data;
    assign w_rt_val = (w_rt_idx == 5'd0) ? 32'd0 : rt_data;
`endif

    // Decode
    logic [31:0] w_op1;
    logic [31:0] w_op2;
    logic [2:0]  w_ctl;
    logic [4:0]  w_rd;
    logic        w_wr_en;
    logic        w_illegal;

    always_comb begin
        w_op1     = 32'd0;
        w_op2     = 32'd0;
        w_ctl     = c_alu_nop;
        w_rd      = 5'd0;
        w_wr_en   = 1'b0;
        w_illegal = 1'b0;
        case (w_opcode)
            c_op_rtype: begin
                w_op1   = w_rs_val;
                w_op2   = w_rt_val;
                w_rd    = w_rd_idx;
                w_wr_en = 1'b1;
                case (w_funct)
                    c_fn_add: w_ctl = c_alu_add;
                    c_fn_sub: w_ctl = c_alu_sub;
                    c_fn_and: w_ctl = c_alu_and;
                    c_fn_or:  w_ctl = c_alu_or;
                    c_fn_xor: w_ctl = c_alu_xor;
                    c_fn_nor: w_ctl = c_alu_nor;
                    c_fn_sll: begin
                        // sll shifts rt by shamt; rs is not a source
                        w_ctl = c_alu_shift;
                        w_op1 = w_rt_val;
                        w_op2 = {27'd0, w_shamt};
                    end
                    default: begin
                        w_op1     = 32'd0;
                        w_op2     = 32'd0;
                        w_rd      = 5'd0;
                        w_wr_en   = 1'b0;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            c_op_addi: begin
                w_ctl   = c_alu_add;
                w_op1   = w_rs_val;
                w_op2   = w_imm_sext;
                w_rd    = w_rt_idx;
                w_wr_en = 1'b1;
            end
            c_op_j: begin
                // Jumps are resolved elsewhere; issue a harmless NOP
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
        // Writes to $0 are discarded
        if (w_rd == 5'd0) begin
            w_wr_en = 1'b0;
        end
    end

    // Output register: reset > flush > accept > drain > hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_op1     <= 32'd0;
            r_op2     <= 32'd0;
            r_ctl     <= c_alu_nop;
            r_rd      <= 5'd0;
            r_wr_en   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_valid   <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_op1     <= w_op1;
            r_op2     <= w_op2;
            r_ctl     <= w_ctl;
            r_rd      <= w_rd;
            r_wr_en   <= w_wr_en;
            r_illegal <= w_illegal;
        end else if (ex_ready) begin
            r_valid   <= 1'b0;
        end
    end

    assign ex_valid    = r_valid;
    assign alu_op1     = r_op1;
    assign alu_op2     = r_op2;
    assign alu_control = r_ctl;
    assign ex_rd       = r_rd;
    assign ex_wr_en    = r_wr_en;
    assign ex_illegal  = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_stage
//  Purpose  : Self-checking bench for alu_issue_stage: directed scenarios
//             plus randomized traffic against a behavioural model.
//  Config   : ALU_ISSUE_FWD_EN selects forwarding expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        exmem_wr_en;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_wr_en;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [2:0]  alu_control;
    logic [4:0]  ex_rd;
    logic        ex_wr_en;
    logic        ex_illegal;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr        (instr),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .exmem_wr_en  (exmem_wr_en),
        .exmem_rd     (exmem_rd),
        .exmem_result (exmem_result),
        .memwb_wr_en  (memwb_wr_en),
        .memwb_rd     (memwb_rd),
        .memwb_result (memwb_result),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .alu_op1      (alu_op1),
        .alu_op2      (alu_op2),
        .alu_control  (alu_control),
        .ex_rd        (ex_rd),
        .ex_wr_en     (ex_wr_en),
        .ex_illegal   (ex_illegal)
    );

    typedef struct packed {
        logic        v;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [2:0]  ctl;
        logic [4:0]  rd;
        logic        wr;
        logic        ill;
    } exp_t;

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Value a source register should read in the accept cycle
    function automatic logic [31:0] src_val(input logic [4:0] r, input logic [31:0] rf);
        if (r == 5'd0) return 32'd0;
`ifdef ALU_ISSUE_FWD_EN
        if (exmem_wr_en && exmem_rd == r) return exmem_result;
        if (memwb_wr_en && memwb_rd == r) return memwb_result;
`endif
        return rf;
    endfunction

    // Reference decode of one instruction against the current input values
    function automatic exp_t model_issue(input logic [31:0] ins);
        exp_t e;
        int   code;
        logic [31:0] s;
        logic [31:0] t;
        e     = '0;
        e.v   = 1'b1;
        e.ctl = 3'b111;
        s     = src_val(ins[25:21], rs_data);
        t     = src_val(ins[20:16], rt_data);
        if (ins[31:26] == 6'd0) begin
            case (ins[5:0])
                6'h20: code = 0;
                6'h22: code = 1;
                6'h00: code = 2;
                6'h24: code = 3;
                6'h25: code = 4;
                6'h26: code = 5;
                6'h27: code = 6;
                default: code = -1;
            endcase
            if (code < 0) begin
                e.ill = 1'b1;
            end else begin
                e.ctl = 3'(code);
                e.op1 = (code == 2) ? t : s;
                e.op2 = (code == 2) ? 32'(ins[10:6]) : t;
                e.rd  = ins[15:11];
                e.wr  = (ins[15:11] != 5'd0);
            end
        end else if (ins[31:26] == 6'b001000) begin
            e.ctl = 3'b000;
            e.op1 = s;
            e.op2 = 32'($signed(ins[15:0]));
            e.rd  = ins[20:16];
            e.wr  = (ins[20:16] != 5'd0);
        end else if (ins[31:26] != 6'b000010) begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs = 5'($urandom_range(0, 7));
        logic [4:0]  rt = 5'($urandom_range(0, 7));
        logic [4:0]  rd = 5'($urandom_range(0, 7));
        logic [4:0]  sh = 5'($urandom);
        logic [5:0]  fns [7] = '{6'h20, 6'h22, 6'h00, 6'h24, 6'h25, 6'h26, 6'h27};
        int k = $urandom_range(0, 10);
        if (k <= 6) return r_type(rs, rt, rd, sh, fns[k]);
        if (k == 7) return i_type(6'b001000, rs, rt, 16'($urandom));
        if (k == 8) return {6'b000010, 26'($urandom)};
        if (k == 9) return r_type(rs, rt, rd, sh, 6'($urandom));
        return $urandom;
    endfunction

    task automatic idle_inputs();
        rst_n = 1'b1; in_valid = 1'b0; instr = 32'd0; rs_data = 32'd0; rt_data = 32'd0;
        exmem_wr_en = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
        memwb_wr_en = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
        flush = 1'b0; ex_ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0; in_valid = 1'b1; ex_ready = 1'b0; flush = 1'b1;
        instr = r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h20); rs_data = 32'd5; rt_data = 32'd7;
        tick();
        tick();
        n_checks++; if (ex_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", ex_valid); else n_pass++;
        n_checks++; if (alu_op1 !== 32'd0) $display("FAIL reset_op1 got %h want 0", alu_op1); else n_pass++;
        n_checks++; if (alu_op2 !== 32'd0) $display("FAIL reset_op2 got %h want 0", alu_op2); else n_pass++;
        n_checks++; if (alu_control !== 3'b111) $display("FAIL reset_ctl got %b want 111", alu_control); else n_pass++;
        n_checks++; if (ex_rd !== 5'd0) $display("FAIL reset_rd got %0d want 0", ex_rd); else n_pass++;
        n_checks++; if (ex_wr_en !== 1'b0) $display("FAIL reset_wr got %b want 0", ex_wr_en); else n_pass++;
        n_checks++; if (ex_illegal !== 1'b0) $display("FAIL reset_ill got %b want 0", ex_illegal); else n_pass++;
        idle_inputs();
        ex_ready = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_add();
        idle_inputs();
        in_valid = 1'b1; instr = r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
        rs_data = 32'd5; rt_data = 32'd7;
        tick();
        in_valid = 1'b0;
        n_checks++; if (ex_valid !== 1'b1) $display("FAIL add_valid got %b want 1", ex_valid); else n_pass++;
        n_checks++; if (alu_op1 !== 32'd5) $display("FAIL add_op1 got %h want 5", alu_op1); else n_pass++;
        n_checks++; if (alu_op2 !== 32'd7) $display("FAIL add_op2 got %h want 7", alu_op2); else n_pass++;
        n_checks++; if (alu_control !== 3'b000) $display("FAIL add_ctl got %b want 000", alu_control); else n_pass++;
        n_checks++; if (ex_rd !== 5'd3) $display("FAIL add_rd got %0d want 3", ex_rd); else n_pass++;
        n_checks++; if (ex_wr_en !== 1'b1) $display("FAIL add_wr got %b want 1", ex_wr_en); else n_pass++;
        tick();
        n_checks++; if (ex_valid !== 1'b0) $display("FAIL add_drain got %b want 0", ex_valid); else n_pass++;
    endtask

    task automatic test_addi();
        idle_inputs();
        in_valid = 1'b1; instr = i_type(6'b001000, 5'd1, 5'd4, 16'hFFFE);
        rs_data = 32'd10; rt_data = $urandom;
        tick();
        in_valid = 1'b0;
        n_checks++; if (alu_op1 !== 32'd10) $display("FAIL addi_op1 got %h want a", alu_op1); else n_pass++;
        n_checks++; if (alu_op2 !== 32'hFFFFFFFE) $display("FAIL addi_op2 got %h want fffffffe", alu_op2); else n_pass++;
        n_checks++; if (alu_control !== 3'b000) $display("FAIL addi_ctl got %b want 000", alu_control); else n_pass++;
        n_checks++; if (ex_rd !== 5'd4) $display("FAIL addi_rd got %0d want 4", ex_rd); else n_pass++;
    endtask

    task automatic test_forward();
        logic [31:0] want;
        idle_inputs();
        in_valid = 1'b1; instr = r_type(5'd1, 5'd1, 5'd5, 5'd0, 6'h20);
        rs_data = 32'h33; rt_data = 32'h33;
        exmem_wr_en = 1'b1; exmem_rd = 5'd1; exmem_result = 32'h11;
        memwb_wr_en = 1'b1; memwb_rd = 5'd1; memwb_result = 32'h22;
`ifdef ALU_ISSUE_FWD_EN
        want = 32'h11;
`else
        want = 32'h33;
`endif
        tick();
        idle_inputs();
        n_checks++; if (alu_op1 !== want) $display("FAIL fwd_op1 got %h want %h", alu_op1, want); else n_pass++;
        n_checks++; if (alu_op2 !== want) $display("FAIL fwd_op2 got %h want %h", alu_op2, want); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        ex_ready = 1'b0; in_valid = 1'b1;
        instr = r_type(5'd7, 5'd8, 5'd6, 5'd0, 6'h22); rs_data = 32'd100; rt_data = 32'd30;
        tick();
        instr = r_type(5'd2, 5'd3, 5'd9, 5'd0, 6'h25); rs_data = 32'hA0; rt_data = 32'h0B;
        for (int i = 0; i < 3; i++) begin
            exmem_wr_en = 1'b1; exmem_rd = 5'd7; exmem_result = $urandom;
            #1;
            n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_ready c%0d got %b want 0", i, in_ready); else n_pass++;
            tick();
            n_checks++;
            if (ex_valid !== 1'b1 || alu_op1 !== 32'd100 || alu_op2 !== 32'd30 || alu_control !== 3'b001 ||
                ex_rd !== 5'd6 || ex_wr_en !== 1'b1)
                $display("FAIL stall_hold c%0d got v%b %h %h %b rd%0d w%b want v1 64 1e 001 rd6 w1",
                         i, ex_valid, alu_op1, alu_op2, alu_control, ex_rd, ex_wr_en);
            else n_pass++;
        end
        exmem_wr_en = 1'b0; ex_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL release_ready got %b want 1", in_ready); else n_pass++;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (ex_valid !== 1'b1 || alu_op1 !== 32'hA0 || alu_op2 !== 32'h0B || alu_control !== 3'b100 || ex_rd !== 5'd9)
            $display("FAIL release_accept got v%b %h %h %b rd%0d want v1 a0 0b 100 rd9",
                     ex_valid, alu_op1, alu_op2, alu_control, ex_rd);
        else n_pass++;
        tick();
    endtask

    task automatic test_flush_illegal();
        idle_inputs();
        ex_ready = 1'b0; in_valid = 1'b1; instr = r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h24);
        tick();
        flush = 1'b1; instr = r_type(5'd4, 5'd5, 5'd6, 5'd0, 6'h20);
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL flush_ready got %b want 0", in_ready); else n_pass++;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (ex_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", ex_valid); else n_pass++;
        tick();
        n_checks++; if (ex_valid !== 1'b0) $display("FAIL flush_drop got %b want 0", ex_valid); else n_pass++;
        in_valid = 1'b1; instr = {6'b111111, 5'd1, 5'd2, 16'h1234}; rs_data = 32'd9; rt_data = 32'd9;
        tick();
        n_checks++;
        if (ex_valid !== 1'b1 || alu_control !== 3'b111 || ex_illegal !== 1'b1 || ex_wr_en !== 1'b0 ||
            alu_op1 !== 32'd0 || alu_op2 !== 32'd0)
            $display("FAIL illegal got v%b ctl%b ill%b wr%b %h %h want v1 111 1 0 0 0",
                     ex_valid, alu_control, ex_illegal, ex_wr_en, alu_op1, alu_op2);
        else n_pass++;
        ex_ready = 1'b1; instr = {6'b000010, 26'h3ABCDEF};
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (ex_valid !== 1'b1 || alu_control !== 3'b111 || ex_illegal !== 1'b0 || ex_wr_en !== 1'b0 ||
            alu_op1 !== 32'd0 || alu_op2 !== 32'd0)
            $display("FAIL jump got v%b ctl%b ill%b wr%b %h %h want v1 111 0 0 0 0",
                     ex_valid, alu_control, ex_illegal, ex_wr_en, alu_op1, alu_op2);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        exp_t m;
        exp_t nx;
        logic exp_ready;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        m = '0; m.ctl = 3'b111;
        for (int i = 0; i < 400; i++) begin
            rst_n        = ($urandom_range(0, 49) != 0);
            in_valid     = ($urandom_range(0, 3) != 0);
            ex_ready     = ($urandom_range(0, 2) != 0);
            flush        = ($urandom_range(0, 15) == 0);
            instr        = rand_instr();
            rs_data      = $urandom;
            rt_data      = $urandom;
            exmem_wr_en  = $urandom_range(0, 1) == 1;
            exmem_rd     = 5'($urandom_range(0, 7));
            exmem_result = $urandom;
            memwb_wr_en  = $urandom_range(0, 1) == 1;
            memwb_rd     = 5'($urandom_range(0, 7));
            memwb_result = $urandom;
            #1;
            exp_ready = (!m.v || ex_ready) && !flush;
            n_checks++;
            if (in_ready !== exp_ready) $display("FAIL rnd_ready c%0d got %b want %b", i, in_ready, exp_ready);
            else n_pass++;
            nx = m;
            if (!rst_n) begin
                nx = '0; nx.ctl = 3'b111;
            end else if (flush) begin
                nx.v = 1'b0;
            end else if (in_valid && exp_ready) begin
                nx = model_issue(instr);
            end else if (ex_ready) begin
                nx.v = 1'b0;
            end
            tick();
            m = nx;
            n_checks++;
            if (ex_valid !== m.v ||
                (m.v && (alu_op1 !== m.op1 || alu_op2 !== m.op2 || alu_control !== m.ctl ||
                         ex_wr_en !== m.wr || ex_illegal !== m.ill ||
                         (m.ctl != 3'b111 && ex_rd !== m.rd))))
                $display("FAIL rnd_out c%0d got v%b %h %h %b rd%0d w%b i%b want v%b %h %h %b rd%0d w%b i%b",
                         i, ex_valid, alu_op1, alu_op2, alu_control, ex_rd, ex_wr_en, ex_illegal,
                         m.v, m.op1, m.op2, m.ctl, m.rd, m.wr, m.ill);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_addi();
        test_forward();
        test_back_to_back();
        test_flush_illegal();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
